// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory controller: FSM states and default NOP word.
package inst_mem_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun
   } state_e;

   localparam logic [31:0] NopDefault = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_ram.sv
// Simple dual-port RAM: synchronous write port, synchronous read port with read enable.
module inst_mem_ram #(
   parameter int unsigned ADDR_BITS  = 8,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

   // Contents are deliberately not reset; rdata holds between reads.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: program-load FSM, fetch fault checking and output register.
module inst_mem_ctrl
   import inst_mem_pkg::*;
#(
   parameter int unsigned            ADDR_BITS  = 8,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  NOP_WORD   = DATA_WIDTH'(NopDefault)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  LoadStart,
   input  logic                  LoadValid,
   output logic                  LoadReady,
   input  logic [DATA_WIDTH-1:0] LoadData,
   input  logic                  LoadLast,
   input  logic                  FetchValid,
   output logic                  FetchReady,
   input  logic [31:0]           Address,
   input  logic                  Stall,
   output logic [DATA_WIDTH-1:0] Instruction,
   output logic                  InstValid,
   output logic                  AddrError,
   output logic [ADDR_BITS:0]    ProgLen
);

   localparam int unsigned DEPTH = 2**ADDR_BITS;

   state_e                state_q, state_d;
   logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
   logic [ADDR_BITS:0]    len_q, len_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  nop_q, nop_d;
   logic                  ram_we, ram_re;
   logic [ADDR_BITS-1:0]  index;
   logic                  fault;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign index = Address[ADDR_BITS+1:2];
   assign fault = (Address[1:0] != 2'b00) || (Address[31:ADDR_BITS+2] != '0) ||
                  ({1'b0, index} >= len_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         nop_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         nop_q   <= nop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      len_d      = len_q;
      valid_d    = valid_q;
      err_d      = err_q;
      nop_d      = nop_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      LoadReady  = 1'b0;
      FetchReady = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (LoadStart) begin
               state_d = StLoad;
               ptr_d   = '0;
               len_d   = '0;
               valid_d = 1'b0;
            end
         end
         StLoad: begin
            LoadReady = 1'b1;
            if (LoadValid) begin
               ram_we = 1'b1;
               ptr_d  = ptr_q + 1'b1;
               len_d  = {1'b0, ptr_q} + 1'b1;
               if (LoadLast || (ptr_q == ADDR_BITS'(DEPTH - 1))) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (LoadStart) begin
               state_d = StLoad;
               ptr_d   = '0;
               len_d   = '0;
               valid_d = 1'b0;
            end else begin
               FetchReady = !(valid_q && Stall);
               if (FetchValid && FetchReady) begin
                  ram_re  = 1'b1;
                  valid_d = 1'b1;
                  err_d   = fault;
                  nop_d   = fault;
               end else if (!Stall) begin
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   inst_mem_ram #(
      .ADDR_BITS  (ADDR_BITS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ptr_q),
      .wdata (LoadData),
      .re    (ram_re),
      .raddr (index),
      .rdata (ram_rdata)
   );

   // The RAM output register doubles as the instruction register; nop_q masks faults and reset.
   assign Instruction = nop_q ? NOP_WORD : ram_rdata;
   assign InstValid   = valid_q;
   assign AddrError   = err_q;
   assign ProgLen     = len_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Randomized self-checking bench for inst_mem_ctrl against a per-cycle behavioural model.
module tb_inst_mem_ctrl;

   localparam int          DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0;

   logic        clk = 1'b0;
   logic        reset, LoadStart, LoadValid, LoadLast, FetchValid, Stall;
   logic        LoadReady, FetchReady, InstValid, AddrError;
   logic [31:0] LoadData, Address, Instruction;
   logic [8:0]  ProgLen;

   int n_total = 0;
   int n_bad   = 0;

   // Model: 0 idle, 1 load, 2 run
   int          m_state, m_ptr, m_len;
   logic        m_valid, m_err;
   logic [31:0] m_inst;
   logic [31:0] m_mem [DEPTH];
   logic [31:0] last_word;

   always #5 clk = ~clk;

   inst_mem_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .LoadStart   (LoadStart),
      .LoadValid   (LoadValid),
      .LoadReady   (LoadReady),
      .LoadData    (LoadData),
      .LoadLast    (LoadLast),
      .FetchValid  (FetchValid),
      .FetchReady  (FetchReady),
      .Address     (Address),
      .Stall       (Stall),
      .Instruction (Instruction),
      .InstValid   (InstValid),
      .AddrError   (AddrError),
      .ProgLen     (ProgLen)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  idx;
      bit  flt;
      if (reset) begin
         m_state = 0; m_ptr = 0; m_len = 0;
         m_valid = 0; m_err = 0; m_inst = NOP;
      end else if (m_state == 0) begin
         if (LoadStart) begin
            m_state = 1; m_ptr = 0; m_len = 0; m_valid = 0;
         end
      end else if (m_state == 1) begin
         if (LoadValid) begin
            m_mem[m_ptr] = LoadData;
            m_ptr = m_ptr + 1;
            m_len = m_ptr;
            if (LoadLast || m_ptr == DEPTH) m_state = 2;
         end
      end else begin
         if (LoadStart) begin
            m_state = 1; m_ptr = 0; m_len = 0; m_valid = 0;
         end else if (FetchValid && !(m_valid && Stall)) begin
            idx = int'(Address / 4) % DEPTH;
            flt = (Address % 4 != 0) || (Address >= 32'(DEPTH * 4)) || (idx >= m_len);
            m_valid = 1;
            m_err   = flt;
            m_inst  = flt ? NOP : m_mem[idx];
         end else if (!Stall) begin
            m_valid = 0;
         end
      end
   endtask

   // Inputs are set after a falling edge; handshake outputs checked before the rising edge.
   task automatic tick();
      #1;
      check_eq("load_ready", LoadReady, m_state == 1);
      if (!LoadStart)
         check_eq("fetch_ready", FetchReady, (m_state == 2) && !(m_valid && Stall));
      @(posedge clk);
      model_edge();
      #1;
      check_eq("inst_valid", InstValid, m_valid);
      check_eq("addr_error", AddrError, m_err);
      check_eq("prog_len", ProgLen, m_len);
      check_eq("instruction", Instruction, m_inst);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      reset = 0; LoadStart = 0; LoadValid = 0; LoadLast = 0; LoadData = '0;
      FetchValid = 0; Address = '0; Stall = 0;
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      LoadValid = 1; LoadData = d; LoadLast = last;
      tick();
      LoadValid = 0; LoadLast = 0;
   endtask

   task automatic fetch(input logic [31:0] a);
      FetchValid = 1; Address = a;
      tick();
      FetchValid = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      model_edge();
      @(negedge clk);
      tick();
      check_eq("rst_inst", Instruction, NOP);
      check_eq("rst_len", ProgLen, 0);
      reset = 0;
      tick();

      // Three-word program
      LoadStart = 1; tick(); LoadStart = 0;
      load_word(32'h2008_0000, 0);
      load_word(32'h2009_0000, 0);
      load_word(32'h200D_0000, 1);
      check_eq("len3", ProgLen, 3);
      tick();
      check_eq("run_ready", FetchReady, 1);

      fetch(32'h4);
      check_eq("f4_inst", Instruction, 32'h2009_0000);
      check_eq("f4_valid", InstValid, 1);
      check_eq("f4_err", AddrError, 0);
      fetch(32'h2);
      check_eq("f2_err", AddrError, 1);
      check_eq("f2_inst", Instruction, NOP);
      fetch(32'hC);
      check_eq("fc_err", AddrError, 1);
      fetch(32'h400);
      check_eq("f400_err", AddrError, 1);
      check_eq("f400_inst", Instruction, NOP);

      // Stall hold
      fetch(32'h0);
      Stall = 1; FetchValid = 1; Address = 32'h4;
      repeat (3) begin
         tick();
         check_eq("stall_inst", Instruction, 32'h2008_0000);
         check_eq("stall_ready", FetchReady, 0);
      end
      Stall = 0;
      tick();
      check_eq("release_inst", Instruction, 32'h2009_0000);
      FetchValid = 0;
      tick();
      check_eq("idle_valid", InstValid, 0);

      // Full-depth load without LoadLast
      LoadStart = 1; tick(); LoadStart = 0;
      for (int i = 0; i < DEPTH; i++) begin
         last_word = $urandom;
         load_word(last_word, 0);
      end
      check_eq("full_len", ProgLen, DEPTH);
      tick();
      fetch(32'h3FC);
      check_eq("full_last", Instruction, last_word);
      check_eq("full_err", AddrError, 0);

      // Reset mid-load
      LoadStart = 1; tick(); LoadStart = 0;
      load_word(32'h1111_1111, 0);
      load_word(32'h2222_2222, 0);
      reset = 1; LoadValid = 1; tick(); reset = 0; LoadValid = 0;
      check_eq("mid_rst_len", ProgLen, 0);
      FetchValid = 1; Address = 32'h0;
      tick();
      check_eq("mid_rst_ready", FetchReady, 0);
      check_eq("mid_rst_valid", InstValid, 0);
      FetchValid = 0;

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(0, 199) == 0);
         LoadStart  = ($urandom_range(0, 24) == 0);
         LoadValid  = ($urandom_range(0, 1) == 1);
         LoadLast   = ($urandom_range(0, 7) == 0);
         LoadData   = $urandom;
         FetchValid = ($urandom_range(0, 9) < 6);
         Stall      = ($urandom_range(0, 9) < 3);
         case ($urandom_range(0, 3))
            0:       Address = $urandom;
            1:       Address = 32'($urandom_range(0, 1023));
            default: Address = 32'($urandom_range(0, 31)) << 2;
         endcase
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
